// File: rtl/proc_if_pkg.sv
// Shared send/ack encodings and receiver state type for the processor handshake.
package proc_if_pkg;

  localparam logic [1:0] SEND_IDLE = 2'b00;
  localparam logic [1:0] SEND_REQ  = 2'b01;

  localparam logic [1:0] ACK_IDLE  = 2'b00;
  localparam logic [1:0] ACK_DONE  = 2'b01;

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } rx_state_t;

  function automatic logic [1:0] ack_of(input rx_state_t s);
    return (s == ACKED) ? ACK_DONE : ACK_IDLE;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous show-ahead FIFO; head word is visible whenever the buffer is non-empty.
module fifo_sync #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fsm_receptor.sv
// Responder side of the send/ack handshake: captures one word per request into a
// show-ahead buffer, stalls while full, and flags illegal send encodings.
module fsm_receptor
  import proc_if_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 send,
  input  logic [DATA_W-1:0]          dado,
  output logic [1:0]                 ack,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       proto_err
);

  rx_state_t  state;
  rx_state_t  state_next;
  logic [1:0] ack_next;
  logic       proto_err_next;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       illegal;

  assign illegal = send[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= ACK_IDLE;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      ack       <= ack_next;
      proto_err <= proto_err_next;
    end
  end

  // Only SEND_IDLE releases ACKED; full is judged on the registered count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (send == SEND_REQ && !full) state_next = ACKED;
      ACKED:   if (send == SEND_IDLE)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_next       = ack_of(state_next);
    proto_err_next = proto_err || illegal;
    wr_en          = (state == IDLE) && (send == SEND_REQ) && !full;
  end

  fifo_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (dado),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign rd_valid = !empty;

endmodule

// File: tb/tb_fsm_receptor.sv
// Directed bench for fsm_receptor with a queue scoreboard of captured words.
module tb_fsm_receptor;

  logic        clk;
  logic        rst;
  logic [1:0]  send;
  logic [15:0] dado;
  logic [1:0]  ack;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [2:0]  count;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb [$];
  bit auto_pop = 0;

  fsm_receptor #(.DATA_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .dado      (dado),
    .ack       (ack),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the expected head first so the compare happens on the word the DUT will pop.
  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(rd_valid), 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(e));
    end
  endtask

  // Advance one cycle; outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (auto_pop) begin
      check("wrap_count_max", 32'(count <= 3'd4), 32'd1);
      if (rd_valid) pop_check("wrap_out");
    end
  endtask

  task automatic handshake(input logic [15:0] d);
    bit seen;
    send = 2'b01;
    dado = d;
    sb.push_back(d);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (ack == 2'b01) seen = 1;
    end
    check("hs_ack_rise", 32'(seen), 32'd1);
    send = 2'b00;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (ack == 2'b00) seen = 1;
    end
    check("hs_ack_fall", 32'(seen), 32'd1);
  endtask

  task automatic drain_one(input string tag);
    pop_check(tag);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; send = 2'b00; dado = '0; rd_en = 1'b0;
    @(negedge clk);
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    rst = 1'b0;

    // Single word: exact one-cycle capture latency.
    send = 2'b01; dado = 16'hA5C3; sb.push_back(16'hA5C3);
    tick();
    check("single_ack", 32'(ack), 32'd1);
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data", 32'(rd_data), 32'hA5C3);
    check("single_count", 32'(count), 32'd1);
    send = 2'b00;
    tick();
    check("single_release", 32'(ack), 32'd0);
    drain_one("single_drain");
    check("single_empty", 32'(count), 32'd0);

    // Fill and stall.
    for (int i = 1; i <= 4; i++) handshake(16'(i));
    check("fill_count", 32'(count), 32'd4);
    send = 2'b01; dado = 16'h0005; sb.push_back(16'h0005);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_ack", 32'(ack), 32'd0);
    end
    check("stall_count", 32'(count), 32'd4);
    pop_check("stall_pop");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("stall_pop_ack", 32'(ack), 32'd0);
    check("stall_pop_count", 32'(count), 32'd3);
    tick();
    check("stall_capture_ack", 32'(ack), 32'd1);
    check("stall_capture_count", 32'(count), 32'd4);
    send = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) drain_one("drain");
    check("drain_valid", 32'(rd_valid), 32'd0);
    check("drain_data", 32'(rd_data), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("underflow_count", 32'(count), 32'd0);

    // Held request captures only once.
    send = 2'b01; dado = 16'h1234; sb.push_back(16'h1234);
    tick();
    check("held_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("held_ack_still", 32'(ack), 32'd1);
    check("held_count", 32'(count), 32'd1);
    send = 2'b00;
    tick();
    check("held_release", 32'(ack), 32'd0);
    drain_one("held_drain");

    // Illegal encoding is sticky until reset.
    send = 2'b11; dado = 16'hDEAD;
    tick();
    check("illegal_perr", 32'(proto_err), 32'd1);
    check("illegal_count", 32'(count), 32'd0);
    check("illegal_ack", 32'(ack), 32'd0);
    send = 2'b00;
    tick();
    handshake(16'h7777);
    check("illegal_sticky", 32'(proto_err), 32'd1);
    drain_one("illegal_drain");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("illegal_rst_clear", 32'(proto_err), 32'd0);

    // Reset while ACKED with two words held.
    handshake(16'hAAAA);
    send = 2'b01; dado = 16'hBBBB;
    tick();
    check("midrst_pre_ack", 32'(ack), 32'd1);
    check("midrst_pre_count", 32'(count), 32'd2);
    rst = 1'b1; send = 2'b00;
    tick();
    rst = 1'b0;
    sb.delete();
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_data", 32'(rd_data), 32'd0);

    // Wrap with continuous popping.
    auto_pop = 1; rd_en = 1'b1;
    for (int i = 0; i < 9; i++) handshake(16'hC000 + 16'(i * 17));
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    auto_pop = 0; rd_en = 1'b0;
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);
    check("wrap_count_end", 32'(count), 32'd0);
    check("wrap_valid_end", 32'(rd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_receptor.md
# fsm_receptor

Responder side of the processor send/ack handshake. Samples `send`, captures the 16-bit `dado` word, and answers on `ack`. Received words are held in a small show-ahead buffer that a downstream consumer drains through a read-enable port. The block sits between the processor FSM (the initiator) and the memory/consumer logic.

## Interface
- `DATA_W`, default 16: width of `dado` and `rd_data`.
- `DEPTH`, default 4: buffer depth in words; must be a power of two and at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `send`  in  2: request from the processor. 2'b00 means idle, 2'b01 means word valid, 2'b10 and 2'b11 are illegal.
- `dado`  in  DATA_W: data word; valid while `send`==2'b01.
- `ack`  out  2: registered response. 2'b00 means idle, 2'b01 means word captured.
- `rd_en`  in  1: consumer pop request.
- `rd_data`  out  DATA_W: head-of-buffer word; forced to 0 when `rd_valid`=0.
- `rd_valid`  out  1: buffer non-empty.
- `count`  out  $clog2(DEPTH+1): number of words currently held.
- `proto_err`  out  1: sticky flag, set on any illegal `send` encoding.

## Operation
- The FSM has two states, IDLE and ACKED. The `ack` output is a registered decode of the state: IDLE gives 2'b00, ACKED gives 2'b01.
- **IDLE state:**
  - If `send`==2'b01 and the buffer is not full, write `dado` to the buffer tail and go to ACKED.
  - If `send`==2'b01 and the buffer is full, stay in IDLE and hold `ack`=2'b00. The block stalls the initiator and drops nothing.
  - If `send`==2'b00, stay in IDLE.
  - If `send` is 2'b10 or 2'b11, set `proto_err` and stay in IDLE. No data is written.
- **ACKED state:**
  - If `send`==2'b00, go to IDLE.
  - If `send`==2'b01, stay in ACKED. The block does not recapture; one word is taken per handshake.
  - If `send` is 2'b10 or 2'b11, set `proto_err` and stay in ACKED. Only 2'b00 releases ACKED.
- **Full test:** the full check uses the registered `count`. A pop in the same cycle does not unblock a capture; the capture happens on the following cycle.
- **Buffer:** show-ahead.
  - `rd_en`=1 while `rd_valid`=1 pops the head.
  - `rd_en` while empty is ignored; there is no underflow and `count` stays 0.
  - A simultaneous write and pop leaves `count` unchanged.
  - The read and write pointers wrap modulo DEPTH.
- **`proto_err`:** cleared only by `rst`.
- **Reset (including mid-handshake):** state goes to IDLE, `ack`=2'b00, pointers and `count`=0, `rd_valid`=0, `rd_data`=0, `proto_err`=0. The buffer contents are discarded. An initiator still holding `send`=2'b01 after `rst` deasserts is treated as a new request.

## Timing
- **Capture latency:** if `send`=2'b01 is sampled in cycle n with the buffer not full, then in cycle n+1 `ack`=2'b01, `count` has incremented, and `rd_valid`=1 if the buffer was empty.
- **Release:** if `send`=2'b00 is sampled in ACKED in cycle m, `ack`=2'b00 in cycle m+1.
- **Minimum handshake:** 4 cycles per word when the initiator responds in a single cycle.
- **Read path:** `rd_data` and `rd_valid` reflect registered pointers only; there is no combinational path from `rd_en`. After a pop in cycle k, the next word, or `rd_valid`=0, is visible in cycle k+1.
- **Combinational paths:** none from `send` or `dado` to any output.

## Structure
- **Package `proc_if_pkg`:**
  - Send encodings: `SEND_IDLE`=2'b00, `SEND_REQ`=2'b01.
  - Ack encodings: `ACK_IDLE`=2'b00, `ACK_DONE`=2'b01.
  - `rx_state_t` enum: {IDLE, ACKED}.
  - The processor FSM uses the same encodings.
- **Sub-module `fifo_sync`:** the synchronous show-ahead FIFO, with parameters `DATA_W` and `DEPTH` and ports `wr_en`/`wr_data`/`rd_en`/`rd_data`/`count`/`full`/`empty`.
- **Top module:** contains the FSM, the `ack` register and `proto_err`.

## Test plan
- **Single word:** from reset, drive `send`=01 with `dado`=16'hA5C3.
  - Expect `ack`=01 the next cycle, then `rd_valid`=1, `rd_data`=16'hA5C3 and `count`=1.
  - Drop `send` to 00; expect `ack`=00 one cycle later.
- **Fill and stall:** perform 4 handshakes of 16'h0001–16'h0004 with no pops, so `count`=4.
  - Start a 5th request with 16'h0005 and hold it for 10 cycles; expect `ack` to stay 00.
  - Pulse `rd_en` once; expect `ack`=01 two cycles after the pop and `count`=4.
  - Drain the buffer; expect the order 2, 3, 4, 5.
- **Held request:** keep `send`=01 for 6 cycles after `ack`=01; expect only one word captured (`count`=1).
- **Illegal encoding:** drive `send`=2'b11 in IDLE; expect `proto_err`=1, `count`=0 and `ack`=00. Expect `proto_err` to stay 1 through later legal traffic until `rst`.
- **Reset mid-handshake:** assert `rst` while in ACKED with `count`=2; the next cycle expect `ack`=00, `count`=0, `rd_valid`=0 and `rd_data`=0.
- **Wrap and concurrency:** run 9 handshakes while popping continuously, so pointers wrap twice and some writes coincide with pops. Expect the output sequence to equal the input sequence and `count` to never exceed 4.
